// File: rtl/fb_bank_arbiter_if.sv
// Framebuffer arbiter bus: display read port, two writer ports, swap control and RAM port.
// The arbiter takes the slave view; display, engines and RAM model take the master view.
interface fb_bank_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 24
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_grant;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              frame_end;

    logic [1:0]        wr_req;
    logic [ADDR_W-1:0] wr_addr0;
    logic [ADDR_W-1:0] wr_addr1;
    logic [DATA_W-1:0] wr_data0;
    logic [DATA_W-1:0] wr_data1;
    logic [1:0]        wr_grant;
    logic              wr_err;

    logic              swap_req;
    logic              swap_pending;
    logic              swap_done;
    logic              front_bank;

    logic [ADDR_W:0]   mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr, frame_end,
        input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
        input  swap_req, mem_rdata,
        output disp_grant, disp_data, disp_valid,
        output wr_grant, wr_err,
        output swap_pending, swap_done, front_bank,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output disp_req, disp_addr, frame_end,
        output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
        output swap_req, mem_rdata,
        input  disp_grant, disp_data, disp_valid,
        input  wr_grant, wr_err,
        input  swap_pending, swap_done, front_bank,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/fb_bank_arbiter.sv
// Double-banked framebuffer arbiter: display reads the front bank, two round-robin engines
// write the back bank, and bank swaps are deferred to the next frame boundary.
module fb_bank_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 24,
    parameter int FB_DEPTH = 4800
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fb_bank_arbiter_if.slave fb
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(FB_DEPTH);

    logic              disp_grant_q, disp_grant_d;
    logic              disp_valid_q;
    logic [1:0]        wr_grant_q, wr_grant_d;
    logic              wr_err_q, wr_err_d;
    logic              rr_q, rr_d;
    logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [0:0]        state_q, state_d;
    logic              front_bank_q, front_bank_d;
    logic              swap_done_q, swap_done_d;

    logic              disp_elig;
    logic [1:0]        wr_elig;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr_sel;
    logic [DATA_W-1:0] wr_data_sel;

    // A requester showing its grant this cycle is still holding req; mask it to avoid a repeat.
    assign disp_elig = fb.disp_req & ~disp_grant_q;
    assign wr_elig   = fb.wr_req & ~wr_grant_q;

    // rr_q names the engine that wins a tie.
    assign wr_sel      = wr_elig[1] & (~wr_elig[0] | rr_q);
    assign wr_addr_sel = wr_sel ? fb.wr_addr1 : fb.wr_addr0;
    assign wr_data_sel = wr_sel ? fb.wr_data1 : fb.wr_data0;

    always_comb begin
        disp_grant_d = 1'b0;
        wr_grant_d   = 2'b00;
        wr_err_d     = wr_err_q;
        rr_d         = rr_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;

        if (disp_elig) begin
            disp_grant_d = 1'b1;
            mem_addr_d   = {front_bank_q, fb.disp_addr};
        end else if (|wr_elig) begin
            wr_grant_d  = wr_sel ? 2'b10 : 2'b01;
            rr_d        = ~wr_sel;
            mem_addr_d  = {~front_bank_q, wr_addr_sel};
            mem_wdata_d = wr_data_sel;
            // Out-of-range writes complete the handshake but never reach the RAM.
            if (wr_addr_sel < DEPTH_LIM) begin
                mem_we_d = 1'b1;
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        front_bank_d = front_bank_q;
        swap_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fb.swap_req && fb.frame_end) begin
                    front_bank_d = ~front_bank_q;
                    swap_done_d  = 1'b1;
                end else if (fb.swap_req) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (fb.frame_end) begin
                    front_bank_d = ~front_bank_q;
                    swap_done_d  = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            disp_grant_q <= 1'b0;
            disp_valid_q <= 1'b0;
            wr_grant_q   <= '0;
            wr_err_q     <= 1'b0;
            rr_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            state_q      <= ST_IDLE;
            front_bank_q <= 1'b0;
            swap_done_q  <= 1'b0;
        end else begin
            disp_grant_q <= disp_grant_d;
            disp_valid_q <= disp_grant_q;
            wr_grant_q   <= wr_grant_d;
            wr_err_q     <= wr_err_d;
            rr_q         <= rr_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            state_q      <= state_d;
            front_bank_q <= front_bank_d;
            swap_done_q  <= swap_done_d;
        end
    end

    assign fb.disp_grant   = disp_grant_q;
    assign fb.disp_valid   = disp_valid_q;
    assign fb.disp_data    = fb.mem_rdata;
    assign fb.wr_grant     = wr_grant_q;
    assign fb.wr_err       = wr_err_q;
    assign fb.swap_pending = (state_q == ST_PENDING);
    assign fb.swap_done    = swap_done_q;
    assign fb.front_bank   = front_bank_q;
    assign fb.mem_addr     = mem_addr_q;
    assign fb.mem_we       = mem_we_q;
    assign fb.mem_wdata    = mem_wdata_q;

endmodule

// File: doc/fb_bank_arbiter.md
Name: fb_bank_arbiter

Overview:
- Owns the single-port, double-banked framebuffer RAM: 2 banks × 4800 words × 24 bits, 80×60 pixels per bank, 1-cycle read latency.
- Shares the RAM between the display pane, which reads the front bank, and two drawing engines, which write the back bank.
- Sequences front/back bank swaps so they occur only on a frame boundary.
- Sits between the game drawing logic and the VGA pixel pipeline.

Parameters:
- ADDR_W, 13, per-bank pixel address width.
- DATA_W, 24, pixel width (RGB 8:8:8).
- FB_DEPTH, 4800, valid words per bank (80×60); addresses ≥ FB_DEPTH are illegal.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- disp_req  in  1  display read request; held until disp_grant.
- disp_addr  in  ADDR_W  display read address, front bank.
- disp_grant  out  1  one-cycle pulse: read accepted.
- disp_data  out  DATA_W  read data; equals mem_rdata.
- disp_valid  out  1  one-cycle pulse: disp_data holds granted read's pixel.
- frame_end  in  1  one-cycle pulse from the display: last pixel of the frame requested.
- wr_req  in  2  write requests; bit i is engine i, held until wr_grant[i].
- wr_addr0, wr_addr1  in  ADDR_W  write addresses, back bank.
- wr_data0, wr_data1  in  DATA_W  write pixels.
- wr_grant  out  2  one-cycle pulse per engine: write accepted.
- wr_err  out  1  sticky: an out-of-range write was dropped.
- swap_req  in  1  one-cycle pulse: request bank swap at next frame_end.
- swap_pending  out  1  swap latched, not yet performed.
- swap_done  out  1  one-cycle pulse: swap performed.
- front_bank  out  1  current display bank.
- mem_addr  out  ADDR_W+1  RAM address, {bank, addr}.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_addr.

Behaviour:
- Reset (rst=0, async): all outputs 0; front_bank=0; RR pointer selects engine 0 first; swap_pending=0; wr_err=0; in-flight read discarded, so disp_valid does not fire after reset release.
- Arbitration, evaluated every cycle t on registered inputs:
  - A requester whose grant is high in cycle t is masked in t, so a held request is never accepted twice.
  - Priority: display over writers.
  - Writers are round-robin: last-granted engine is lowest priority next time; the pointer updates only on a write grant.
  - At most one operation is issued per cycle.
- Issue, registered at edge t+1:
  - Read: mem_addr={front_bank, disp_addr}, mem_we=0, disp_grant=1.
  - Write: mem_addr={~front_bank, wr_addrN}, mem_wdata=wr_dataN, mem_we=1, wr_grant[N]=1.
  - Idle: mem_we=0; mem_addr holds its last value.
  - Bank bit is sampled at decision time.
- Read latency: disp_valid=1 at cycle t+2, with disp_data=mem_rdata. Request to data is 2 cycles.
- Out-of-range write (addr ≥ FB_DEPTH): still granted, mem_we=0, wr_err set; wr_err clears only on reset. Out-of-range reads are passed through unchecked.
- Swap sequencing, states IDLE and PENDING:
  - IDLE: swap_req → PENDING, swap_pending=1.
  - PENDING: frame_end → toggle front_bank, pulse swap_done, return to IDLE. All three take effect at the same edge.
  - swap_req and frame_end in the same cycle from IDLE: swap performed on that edge.
  - swap_req while PENDING: ignored; swaps do not queue.
  - frame_end in IDLE: no effect.
- Swap boundary: ops decided in the toggle cycle use the old front_bank; ops decided from the next cycle use the new one. A read issued before the toggle completes normally from the old bank.
- Fairness: the display requests at most every other cycle, so writers are guaranteed at least one slot per two cycles. With both engines continuously requesting, grants alternate 0,1,0,1.

Test Plan:
- Reset then single display read: disp_req=1, disp_addr=0x12C, front_bank=0 → disp_grant at t+1 with mem_addr=0x012C and mem_we=0; disp_valid at t+2 with disp_data=mem_rdata.
- Both engines requesting continuously, display idle: writes to 0x000 (data 0xFF0000) and 0x001 (data 0x00FF00) → wr_grant sequence 01,10,01…; each issue has mem_addr bit13=1 and mem_we=1.
- Display and engine 0 request in the same cycle → display granted first; engine 0 granted the following cycle; no double grant while req is held.
- Engine 1 writes addr 4800 → wr_grant[1]=1, mem_we=0, wr_err=1 until reset.
- swap_req, then frame_end 10 cycles later → swap_pending=1 for those cycles; then swap_done pulse and front_bank=1; next read mem_addr bit13=1, next write bit13=0. Repeat with swap_req and frame_end in the same cycle → immediate swap.
- Assert rst low mid-read, at t+1 → all outputs 0 immediately, no disp_valid after release; first post-reset write grant goes to engine 0.
